// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the data-memory stage.
// Imported by mem_stage and mem_stage_ram.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_BYTE: m = 4'b0001 << off;
            SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // True when size is legal and the offset is naturally aligned for it.
    function automatic logic access_ok(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            SZ_WORD: ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// Word-organised RAM with byte-enable writes and a
// fixed-depth registered read pipeline.
module mem_stage_ram
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int READ_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] pipe_q [READ_LAT];

    // Byte-lane write; untouched lanes keep their contents.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Read captured on issue, then shifted down the latency pipe.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            pipe_q[0] <= mem[i_addr];
        end
        for (int k = 1; k < READ_LAT; k++) begin
            pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign o_rdata = pipe_q[READ_LAT-1];

endmodule

// File: rtl/mem_stage.sv
// Data-memory stage: load/store with extension, alignment
// checking, writeback mux and a stall handshake for loads.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int READ_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_alu,
    input  logic [31:0] i_data,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic        i_memToReg,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_stall,
    output logic        o_misalign
);

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $error("mem_stage: READ_LAT must be in 1..4");
    end

    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    logic        state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic [31:0] alu_q, alu_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        m2r_q, m2r_d;

    logic        accept;
    logic        is_store;
    logic        is_load;
    logic        ok;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] shifted;
    logic [31:0] ext;

    assign accept   = (state_q == ST_IDLE) && i_valid;
    assign is_store = i_memWrite;
    assign is_load  = i_memRead && !i_memWrite;
    assign ok       = access_ok(i_size, i_alu[1:0]);
    assign be       = byte_en(i_size, i_alu[1:0]);

    // Replicate store data across lanes; the byte enables pick the live ones.
    always_comb begin
        wdata = i_data;
        case (i_size)
            SZ_BYTE: wdata = {4{i_data[7:0]}};
            SZ_HALF: wdata = {2{i_data[15:0]}};
            default: wdata = i_data;
        endcase
    end

    mem_stage_ram #(
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (accept && is_store && ok),
        .i_be    (be),
        .i_re    (accept && is_load && ok),
        .i_addr  (i_alu[ADDR_W+1:2]),
        .i_wdata (wdata),
        .o_rdata (rdata)
    );

    // Extract the addressed byte/half and sign- or zero-extend it.
    always_comb begin
        shifted = rdata >> {off_q, 3'b000};
        ext     = rdata;
        case (size_q)
            SZ_BYTE: ext = uns_q ? {24'b0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: ext = uns_q ? {16'b0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = rdata;
        endcase
    end

    // Acceptance, load wait countdown and writeback selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        mis_d   = 1'b0;
        alu_d   = alu_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        m2r_d   = m2r_q;
        if (state_q == ST_WAIT) begin
            if (cnt_q == 2'd0) begin
                state_d = ST_IDLE;
                valid_d = 1'b1;
                data_d  = m2r_q ? ext : alu_q;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end else if (accept) begin
            if ((is_store || is_load) && !ok) begin
                valid_d = 1'b1;
                mis_d   = 1'b1;
                data_d  = 32'h0;
            end else if (is_load) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_INIT;
                alu_d   = i_alu;
                off_d   = i_alu[1:0];
                size_d  = i_size;
                uns_d   = i_unsigned;
                m2r_d   = i_memToReg;
            end else begin
                valid_d = 1'b1;
                data_d  = i_alu;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            data_q  <= 32'h0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            alu_q   <= 32'h0;
            off_q   <= 2'b00;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            m2r_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            alu_q   <= alu_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            m2r_q   <= m2r_d;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_stall    = (state_q == ST_WAIT);
    assign o_misalign = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: two instances (READ_LAT 1 and 3)
// checked against a byte-array memory model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int AW = 6;
    localparam int NB = 1 << (AW + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        vld  [2];
    logic [31:0] alu  [2];
    logic [31:0] dat  [2];
    logic        rd   [2];
    logic        wr   [2];
    logic        m2r  [2];
    logic [1:0]  sz   [2];
    logic        uns  [2];
    logic [31:0] odat [2];
    logic        oval [2];
    logic        ostl [2];
    logic        omis [2];

    int errors = 0;
    int checks = 0;

    logic [7:0] mdl [2][NB];

    mem_stage #(.ADDR_W(AW), .READ_LAT(1)) u_l1 (
        .i_clk(clk), .i_rst(rst[0]), .i_valid(vld[0]),
        .i_alu(alu[0]), .i_data(dat[0]),
        .i_memRead(rd[0]), .i_memWrite(wr[0]),
        .i_memToReg(m2r[0]), .i_size(sz[0]),
        .i_unsigned(uns[0]), .o_data(odat[0]),
        .o_valid(oval[0]), .o_stall(ostl[0]),
        .o_misalign(omis[0])
    );

    mem_stage #(.ADDR_W(AW), .READ_LAT(3)) u_l3 (
        .i_clk(clk), .i_rst(rst[1]), .i_valid(vld[1]),
        .i_alu(alu[1]), .i_data(dat[1]),
        .i_memRead(rd[1]), .i_memWrite(wr[1]),
        .i_memToReg(m2r[1]), .i_size(sz[1]),
        .i_unsigned(uns[1]), .o_data(odat[1]),
        .o_valid(oval[1]), .o_stall(ostl[1]),
        .o_misalign(omis[1])
    );

    function automatic int rl_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    function automatic logic legal(input logic [1:0] z, input logic [31:0] a);
        if (z == 2'd0) return 1'b1;
        if (z == 2'd1) return (a % 2) == 0;
        if (z == 2'd2) return (a % 4) == 0;
        return 1'b0;
    endfunction

    function automatic int nbytes(input logic [1:0] z);
        if (z == 2'd0) return 1;
        if (z == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] mdl_load(input int s, input logic [1:0] z,
                                             input logic [31:0] a, input logic u);
        logic [31:0] w;
        int n;
        w = 0;
        n = nbytes(z);
        for (int i = 0; i < n; i++) w[8*i +: 8] = mdl[s][(a + i) % NB];
        if (!u && n == 1 && w[7])  w = w | 32'hFFFF_FF00;
        if (!u && n == 2 && w[15]) w = w | 32'hFFFF_0000;
        return w;
    endfunction

    // Expected writeback, misalign flag and latency; updates the model on stores.
    task automatic expect_req(input int s, input logic r, input logic w,
                              input logic m, input logic [1:0] z, input logic u,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] ed, output logic em,
                              output int el);
        em = 1'b0;
        el = 1;
        ed = a;
        if ((r || w) && !legal(z, a)) begin
            em = 1'b1;
            ed = 32'h0;
        end else if (w) begin
            for (int i = 0; i < nbytes(z); i++) mdl[s][(a + i) % NB] = d[8*i +: 8];
        end else if (r) begin
            ed = m ? mdl_load(s, z, a, u) : a;
            el = rl_of(s) + 1;
        end
    endtask

    // Drive one request from a negedge and wait (bounded) for its result.
    task automatic run(input int s, input logic r, input logic w,
                       input logic m, input logic [1:0] z, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] od, output logic om,
                       output int lat, output int stl);
        int g;
        g = 0;
        while (ostl[s] && g < 20) begin
            @(negedge clk);
            g++;
        end
        rd[s] = r; wr[s] = w; m2r[s] = m; sz[s] = z;
        uns[s] = u; alu[s] = a; dat[s] = d; vld[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[s] = 1'b0;
        lat = 1;
        stl = 0;
        while (!oval[s] && lat < 20) begin
            if (ostl[s]) stl++;
            @(negedge clk);
            lat++;
        end
        if (!oval[s]) lat = -1;
        od = odat[s];
        om = omis[s];
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) rst[s] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (odat[s] !== 32'h0 || oval[s] !== 1'b0 ||
                ostl[s] !== 1'b0 || omis[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d] got d=%h v=%b s=%b m=%b want 0",
                         s, odat[s], oval[s], ostl[s], omis[s]);
            end
            rst[s] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic init_mem();
        logic [31:0] od, ed;
        logic om, em;
        int lat, stl, el;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NB / 4; i++) begin
                expect_req(s, 0, 1, 0, SZ_WORD, 0, 32'(i * 4), 0, ed, em, el);
                run(s, 0, 1, 0, SZ_WORD, 0, 32'(i * 4), 0, od, om, lat, stl);
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] od, ed;
        logic om, em;
        int lat, stl, el;
        expect_req(0, 0, 1, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, ed, em, el);
        run(0, 0, 1, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, od, om, lat, stl);
        checks++;
        if (od !== 32'h10 || lat != 1 || om !== 1'b0) begin
            errors++;
            $display("FAIL word_store got d=%h lat=%0d m=%b want 10 lat=1", od, lat, om);
        end
        expect_req(0, 1, 0, 1, SZ_WORD, 0, 32'h10, 0, ed, em, el);
        run(0, 1, 0, 1, SZ_WORD, 0, 32'h10, 0, od, om, lat, stl);
        checks++;
        if (od !== 32'hDEADBEEF || lat != 2 || stl != 1) begin
            errors++;
            $display("FAIL word_load got d=%h lat=%0d stl=%0d want deadbeef 2 1",
                     od, lat, stl);
        end
    endtask

    task automatic test_subword();
        logic [31:0] od, ed;
        logic om, em;
        int lat, stl, el;
        expect_req(0, 0, 1, 0, SZ_WORD, 0, 32'h20, 0, ed, em, el);
        run(0, 0, 1, 0, SZ_WORD, 0, 32'h20, 0, od, om, lat, stl);
        expect_req(0, 0, 1, 0, SZ_BYTE, 0, 32'h21, 32'h80, ed, em, el);
        run(0, 0, 1, 0, SZ_BYTE, 0, 32'h21, 32'h80, od, om, lat, stl);
        expect_req(0, 0, 1, 0, SZ_HALF, 0, 32'h22, 32'h8001, ed, em, el);
        run(0, 0, 1, 0, SZ_HALF, 0, 32'h22, 32'h8001, od, om, lat, stl);
        run(0, 1, 0, 1, SZ_BYTE, 0, 32'h21, 0, od, om, lat, stl);
        checks++;
        if (od !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb_signed got %h want ffffff80", od);
        end
        run(0, 1, 0, 1, SZ_BYTE, 1, 32'h21, 0, od, om, lat, stl);
        checks++;
        if (od !== 32'h00000080) begin
            errors++;
            $display("FAIL lb_unsigned got %h want 00000080", od);
        end
        run(0, 1, 0, 1, SZ_HALF, 0, 32'h22, 0, od, om, lat, stl);
        checks++;
        if (od !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL lh_signed got %h want ffff8001", od);
        end
        run(0, 1, 0, 1, SZ_WORD, 0, 32'h20, 0, od, om, lat, stl);
        checks++;
        if (od !== 32'h80018000) begin
            errors++;
            $display("FAIL lw_merge got %h want 80018000", od);
        end
        run(0, 1, 0, 0, SZ_WORD, 0, 32'h20, 0, od, om, lat, stl);
        checks++;
        if (od !== 32'h20 || lat != 2) begin
            errors++;
            $display("FAIL load_no_m2r got %h lat=%0d want 20 lat=2", od, lat);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] od, ed;
        logic om, em;
        int lat, stl, el;
        expect_req(0, 0, 1, 0, SZ_WORD, 0, 32'h04, 32'hA5A55A5A, ed, em, el);
        run(0, 0, 1, 0, SZ_WORD, 0, 32'h04, 32'hA5A55A5A, od, om, lat, stl);
        run(0, 0, 1, 0, SZ_WORD, 0, 32'h06, 32'h11111111, od, om, lat, stl);
        checks++;
        if (om !== 1'b1 || od !== 32'h0 || lat != 1 || stl != 0) begin
            errors++;
            $display("FAIL mis_sw got m=%b d=%h lat=%0d want 1 0 1", om, od, lat);
        end
        run(0, 1, 0, 1, SZ_HALF, 0, 32'h03, 0, od, om, lat, stl);
        checks++;
        if (om !== 1'b1 || od !== 32'h0 || lat != 1 || stl != 0) begin
            errors++;
            $display("FAIL mis_lh got m=%b d=%h lat=%0d want 1 0 1", om, od, lat);
        end
        run(0, 1, 0, 1, 2'b11, 0, 32'h04, 0, od, om, lat, stl);
        checks++;
        if (om !== 1'b1 || od !== 32'h0 || lat != 1 || stl != 0) begin
            errors++;
            $display("FAIL mis_sz3 got m=%b d=%h lat=%0d want 1 0 1", om, od, lat);
        end
        run(0, 0, 1, 0, 2'b11, 0, 32'h04, 32'h22222222, od, om, lat, stl);
        run(0, 1, 0, 1, SZ_WORD, 0, 32'h04, 0, od, om, lat, stl);
        checks++;
        if (od !== 32'hA5A55A5A || om !== 1'b0) begin
            errors++;
            $display("FAIL mis_nowrite got %h m=%b want a5a55a5a 0", od, om);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ed;
        logic em;
        int el;
        expect_req(1, 1, 0, 1, SZ_WORD, 0, 32'h10, 0, ed, em, el);
        rd[1] = 0; wr[1] = 0; m2r[1] = 0; sz[1] = SZ_WORD;
        alu[1] = 32'h1111; vld[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (oval[1] !== 1'b1 || odat[1] !== 32'h1111) begin
            errors++;
            $display("FAIL b2b_alu0 got v=%b d=%h want 1 1111", oval[1], odat[1]);
        end
        alu[1] = 32'h2222;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (oval[1] !== 1'b1 || odat[1] !== 32'h2222) begin
            errors++;
            $display("FAIL b2b_alu1 got v=%b d=%h want 1 2222", oval[1], odat[1]);
        end
        rd[1] = 1; m2r[1] = 1; alu[1] = 32'h10;
        @(posedge clk);
        @(negedge clk);
        rd[1] = 0; m2r[1] = 0; alu[1] = 32'h3333;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (ostl[1] !== 1'b1 || oval[1] !== 1'b0 || omis[1] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall%0d got s=%b v=%b m=%b want 1 0 0",
                         c, ostl[1], oval[1], omis[1]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (oval[1] !== 1'b1 || ostl[1] !== 1'b0 || odat[1] !== ed) begin
            errors++;
            $display("FAIL b2b_load got v=%b s=%b d=%h want 1 0 %h",
                     oval[1], ostl[1], odat[1], ed);
        end
        @(posedge clk);
        @(negedge clk);
        vld[1] = 1'b0;
        checks++;
        if (oval[1] !== 1'b1 || odat[1] !== 32'h3333) begin
            errors++;
            $display("FAIL b2b_trail got v=%b d=%h want 1 3333", oval[1], odat[1]);
        end
        @(negedge clk);
        checks++;
        if (oval[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse got v=%b want 0", oval[1]);
        end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] od, ed;
        logic om, em;
        int lat, stl, el, seen;
        expect_req(0, 0, 1, 0, SZ_WORD, 0, 32'h100, 32'h12345678, ed, em, el);
        run(0, 0, 1, 0, SZ_WORD, 0, 32'h100, 32'h12345678, od, om, lat, stl);
        run(0, 1, 0, 1, SZ_WORD, 0, 32'h000, 0, od, om, lat, stl);
        checks++;
        if (od !== 32'h12345678) begin
            errors++;
            $display("FAIL wrap got %h want 12345678", od);
        end
        expect_req(1, 0, 1, 0, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, ed, em, el);
        run(1, 0, 1, 0, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, od, om, lat, stl);
        rd[1] = 1; wr[1] = 0; m2r[1] = 1; sz[1] = SZ_WORD;
        alu[1] = 32'h40; vld[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[1] = 1'b0;
        checks++;
        if (ostl[1] !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_pre got s=%b want 1", ostl[1]);
        end
        rst[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        checks++;
        if (ostl[1] !== 1'b0 || oval[1] !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait got s=%b v=%b want 0 0", ostl[1], oval[1]);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (oval[1] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_novalid got %0d pulses want 0", seen);
        end
        run(1, 1, 0, 1, SZ_WORD, 0, 32'h40, 0, od, om, lat, stl);
        checks++;
        if (od !== 32'hCAFEF00D || lat != 4 || stl != 3) begin
            errors++;
            $display("FAIL rst_retain got %h lat=%0d stl=%0d want cafef00d 4 3",
                     od, lat, stl);
        end
    endtask

    task automatic test_random();
        logic [31:0] od, ed, a, d;
        logic om, em, r, w, m, u;
        logic [1:0] z;
        int lat, stl, el, s, op;
        for (int n = 0; n < 300; n++) begin
            s  = $urandom_range(0, 1);
            op = $urandom_range(0, 6);
            r  = (op >= 3 && op <= 5) || op == 6;
            w  = (op == 1 || op == 2 || op == 6);
            m  = 1'($urandom_range(0, 3) != 0);
            u  = 1'($urandom_range(0, 1));
            z  = 2'($urandom_range(0, 3));
            d  = $urandom;
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (z == SZ_HALF) a[0] = 1'b0;
                if (z == SZ_WORD) a[1:0] = 2'b00;
            end
            expect_req(s, r, w, m, z, u, a, d, ed, em, el);
            run(s, r, w, m, z, u, a, d, od, om, lat, stl);
            checks++;
            if (od !== ed || om !== em || lat != el || stl != el - 1) begin
                errors++;
                $display("FAIL rand%0d s=%0d op=%0d z=%0d a=%h got d=%h m=%b lat=%0d stl=%0d want d=%h m=%b lat=%0d",
                         n, s, op, z, a, od, om, lat, stl, ed, em, el);
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; vld[s] = 1'b0; alu[s] = 0; dat[s] = 0;
            rd[s] = 0; wr[s] = 0; m2r[s] = 0; sz[s] = 0; uns[s] = 0;
            for (int i = 0; i < NB; i++) mdl[s][i] = 8'h00;
        end
        test_reset();
        init_mem();
        test_word();
        test_subword();
        test_misalign();
        test_back_to_back();
        test_wrap_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
